ram_cmd_master: RTL and testbench
=================================

// Module: ram_cmd_master
// PURPOSE
//  Initiator for the 2-bit-opcode RAM command interface: turns single-beat host write/read requests
//  into the command-word sequence the RAM consumes (00 wr_addr, 01 wr_data, 10 rd_addr, 11 rd_data).
//  Captures the RAM's read reply (tx_valid/tx_data) and returns it as a one-cycle host response.
//  Sits between the bus/test host and the RAM, in place of the SPI slave, for bring-up and RAM-only benches.
// PARAMETERS
//  MEM_DEPTH   256  RAM depth; ADDR_SIZE = $clog2(MEM_DEPTH) (localparam)
//  GAP         0    idle cycles (cmd_valid low) inserted between the two command words of one request
//  TIMEOUT     15   max cycles in RSP_WAIT before the read is aborted with rsp_err (>=1)
//  ADDR_CACHE  1    1: skip the address word when the address matches the last one sent for that direction
// PORTS
//  clk        in   1             single clock, all logic on posedge
//  rst        in   1             synchronous, active-high reset
//  req_valid  in   1             host request present
//  req_ready  out  1             master can accept a request (high only in IDLE)
//  req_write  in   1             1 write, 0 read
//  req_addr   in   ADDR_SIZE     target address
//  req_wdata  in   ADDR_SIZE     write data (ignored for reads)
//  cmd_valid  out  1             command word valid -> RAM rx_valid
//  cmd_data   out  ADDR_SIZE+2   {opcode[1:0], payload} -> RAM rx_data
//  tx_valid   in   1             RAM read-data valid
//  tx_data    in   ADDR_SIZE     RAM read data
//  rsp_valid  out  1             one-cycle pulse: read completed or aborted
//  rsp_data   out  ADDR_SIZE     read data, valid with rsp_valid (0 on error)
//  rsp_err    out  1             qualifies rsp_valid: 1 = timeout
//  busy       out  1             ~req_ready
// BEHAVIOUR
//  Reset (rst=1 at a posedge): state IDLE; req_ready=1; cmd_valid=0; cmd_data=0; rsp_valid=0; rsp_data=0;
//   rsp_err=0; gap/timeout counters=0; both address caches invalid. Reset mid-sequence aborts with no response.
//  States: IDLE, ADDR, GAP_W, DATA, RSP_WAIT. All outputs registered.
//  Accept at edge T when req_valid&&req_ready; req_write/addr/wdata latched at T.
//  ADDR (cycle after T): cmd_valid=1, cmd_data={00 or 10, addr}; skipped (go straight to DATA) when
//   ADDR_CACHE=1 and the matching cache is valid and equal to addr; with no skip, GAP_W then follows.
//  GAP_W: GAP cycles of cmd_valid=0, cmd_data held; zero cycles when GAP=0.
//  DATA: cmd_valid=1 for exactly one cycle; write: {01, wdata}; read: {11, 0}.
//  Write: DATA -> IDLE; req_ready high the cycle after the DATA word; no host response.
//  Read: DATA -> RSP_WAIT. tx_valid/tx_data are sampled only in RSP_WAIT (stale tx_valid elsewhere ignored).
//   First RSP_WAIT cycle with tx_valid=1: next cycle rsp_valid=1, rsp_data=tx_data, rsp_err=0, state IDLE.
//   Minimum read latency, cache miss, GAP=0: accept T, 10 at T+1, 11 at T+2, rsp_valid at T+4.
//   TIMEOUT cycles without tx_valid: rsp_valid=1, rsp_err=1, rsp_data=0, read cache invalidated, IDLE.
//  Caches: write-address cache updated when a 00 word is issued; read cache when a 10 word is issued.
//  Back-to-back: req_valid held high in IDLE is accepted the same cycle req_ready is seen;
//   at most one request in flight; req_valid during busy is not accepted and is held by the host.
//  cmd_valid is never high in two consecutive cycles unless GAP=0.
// TESTING
//  Write 0x3C to addr 0x12 (GAP=0, cache cold) -> cmd 0x012 at T+1, 0x13C at T+2, cmd_valid low at T+3.
//  Read addr 0x12, RAM model returns 0x3C -> cmd 0x212, 0x300, rsp_valid at T+4 with rsp_data=0x3C.
//  Second write to 0x12 with ADDR_CACHE=1 -> only 0x1xx word issued; with ADDR_CACHE=0 both words issued.
//  GAP=3 write -> exactly 3 cmd_valid-low cycles between 0x0xx and 0x1xx words.
//  Read with tx_valid tied 0, TIMEOUT=15 -> rsp_valid=1, rsp_err=1, rsp_data=0; next read re-sends 10 word.
//  rst asserted between the address and data words -> outputs at reset values next cycle, no 01/11 word, no rsp.

Source files
------------

// File: rtl/ram_cmd_master.sv
// rtl/ram_cmd_master.sv - host request to RAM command-word sequencer
// Issues address/data command words per request; returns read replies as one-cycle responses.
module ram_cmd_master #(
  parameter int MEM_DEPTH  = 256,
  parameter int GAP        = 0,
  parameter int TIMEOUT    = 15,
  parameter int ADDR_CACHE = 1,
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_write,
  input  logic [ADDR_SIZE-1:0]   i_req_addr,
  input  logic [ADDR_SIZE-1:0]   i_req_wdata,
  output logic                   o_cmd_valid,
  output logic [ADDR_SIZE+1:0]   o_cmd_data,
  input  logic                   i_tx_valid,
  input  logic [ADDR_SIZE-1:0]   i_tx_data,
  output logic                   o_rsp_valid,
  output logic [ADDR_SIZE-1:0]   o_rsp_data,
  output logic                   o_rsp_err,
  output logic                   o_busy
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP_W, S_DATA, S_RSP_WAIT} state_t;

  state_t                 r_state;
  logic                   r_req_ready;
  logic                   r_busy;
  logic                   r_cmd_valid;
  logic [ADDR_SIZE+1:0]   r_cmd_data;
  logic                   r_rsp_valid;
  logic [ADDR_SIZE-1:0]   r_rsp_data;
  logic                   r_rsp_err;
  logic                   r_write;
  logic [ADDR_SIZE-1:0]   r_wdata;
  logic [GW-1:0]          r_gap_cnt;
  logic [TW-1:0]          r_to_cnt;
  logic                   r_wc_vld;
  logic [ADDR_SIZE-1:0]   r_wc_addr;
  logic                   r_rc_vld;
  logic [ADDR_SIZE-1:0]   r_rc_addr;

  logic                   w_hit;
  logic [ADDR_SIZE+1:0]   w_acc_data;
  logic [ADDR_SIZE+1:0]   w_data_word;

  // Address word is redundant when the RAM already holds this address for the same direction.
  assign w_hit = (ADDR_CACHE != 0) &&
                 (i_req_write ? (r_wc_vld && (r_wc_addr == i_req_addr))
                              : (r_rc_vld && (r_rc_addr == i_req_addr)));
  assign w_acc_data  = i_req_write ? {2'b01, i_req_wdata} : {2'b11, {ADDR_SIZE{1'b0}}};
  assign w_data_word = r_write ? {2'b01, r_wdata} : {2'b11, {ADDR_SIZE{1'b0}}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_gap_cnt   <= '0;
      r_to_cnt    <= '0;
      r_wc_vld    <= 1'b0;
      r_wc_addr   <= '0;
      r_rc_vld    <= 1'b0;
      r_rc_addr   <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_write     <= i_req_write;
            r_wdata     <= i_req_wdata;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_cmd_valid <= 1'b1;
            if (w_hit) begin
              r_cmd_data <= w_acc_data;
              r_state    <= S_DATA;
            end else begin
              r_cmd_data <= {i_req_write ? 2'b00 : 2'b10, i_req_addr};
              r_state    <= S_ADDR;
              if (i_req_write) begin
                r_wc_vld  <= 1'b1;
                r_wc_addr <= i_req_addr;
              end else begin
                r_rc_vld  <= 1'b1;
                r_rc_addr <= i_req_addr;
              end
            end
          end
        end
        S_ADDR: begin
          if (GAP == 0) begin
            r_cmd_data <= w_data_word;
            r_state    <= S_DATA;
          end else begin
            r_cmd_valid <= 1'b0;
            r_gap_cnt   <= '0;
            r_state     <= S_GAP_W;
          end
        end
        S_GAP_W: begin
          if (r_gap_cnt == GW'(GAP - 1)) begin
            r_cmd_valid <= 1'b1;
            r_cmd_data  <= w_data_word;
            r_state     <= S_DATA;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        S_DATA: begin
          r_cmd_valid <= 1'b0;
          if (r_write) begin
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_to_cnt <= '0;
            r_state  <= S_RSP_WAIT;
          end
        end
        S_RSP_WAIT: begin
          if (i_tx_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= i_tx_data;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
            // Unknown RAM read pointer after an abort: force the next read to resend its address.
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
            r_rc_vld    <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_busy      = r_busy;
  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_data  = r_cmd_data;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ram_cmd_master.sv
// tb/tb_ram_cmd_master.sv - scoreboard bench for ram_cmd_master
// Two instances (GAP=0 cached / GAP=3 uncached) each driving a behavioural RAM.
module tb_ram_cmd_master;

  localparam int TO0 = 15;
  localparam int TO1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst;
  logic [1:0] req_valid;
  logic [1:0] req_write;
  logic [7:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  bit         mute      [2];

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_cmd0 [$];
  logic [9:0] exp_cmd1 [$];
  logic [8:0] exp_rsp0 [$];
  logic [8:0] exp_rsp1 [$];

  logic [7:0] ref_mem [2][256];
  bit         wc_v [2];
  bit         rc_v [2];
  logic [7:0] wc   [2];
  logic [7:0] rc   [2];

  function automatic int cmd_size(input int d);
    return (d == 0) ? exp_cmd0.size() : exp_cmd1.size();
  endfunction

  function automatic int rsp_size(input int d);
    return (d == 0) ? exp_rsp0.size() : exp_rsp1.size();
  endfunction

  function automatic logic [9:0] pop_cmd(input int d);
    if (d == 0) return exp_cmd0.pop_front();
    return exp_cmd1.pop_front();
  endfunction

  function automatic logic [8:0] pop_rsp(input int d);
    if (d == 0) return exp_rsp0.pop_front();
    return exp_rsp1.pop_front();
  endfunction

  function automatic void push_cmd(input int d, input logic [9:0] w);
    if (d == 0) exp_cmd0.push_back(w);
    else exp_cmd1.push_back(w);
  endfunction

  function automatic void push_rsp(input int d, input logic [8:0] r);
    if (d == 0) exp_rsp0.push_back(r);
    else exp_rsp1.push_back(r);
  endfunction

  genvar g;
  for (g = 0; g < 2; g++) begin : g_ch
    localparam int GAPV   = (g == 0) ? 0 : 3;
    localparam int TOV    = (g == 0) ? TO0 : TO1;
    localparam int CACHEV = (g == 0) ? 1 : 0;

    logic       req_ready, cmd_valid, tx_valid, rsp_valid, rsp_err, busy;
    logic [7:0] tx_data, rsp_data;
    logic [9:0] cmd_data;
    logic [7:0] mem [256];
    logic [7:0] wa, ra;
    logic       rd_pend;
    int         n = 0, acc_n = 0, last_n = 0, data_n = 0, want_n;
    bit         first_pending = 0;
    logic [9:0] want_cmd;
    logic [8:0] want_rsp;

    ram_cmd_master #(.MEM_DEPTH(256), .GAP(GAPV), .TIMEOUT(TOV), .ADDR_CACHE(CACHEV)) u_dut (
      .i_clk(clk), .i_rst(rst[g]),
      .i_req_valid(req_valid[g]), .o_req_ready(req_ready),
      .i_req_write(req_write[g]), .i_req_addr(req_addr[g]), .i_req_wdata(req_wdata[g]),
      .o_cmd_valid(cmd_valid), .o_cmd_data(cmd_data),
      .i_tx_valid(tx_valid), .i_tx_data(tx_data),
      .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
      .o_busy(busy)
    );

    // Behavioural RAM: registers each command word, answers a read one cycle after its 11 word.
    always @(negedge clk) begin
      if (rst[g]) begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        tx_valid <= 1'b0;
        tx_data  <= 8'h00;
        rd_pend  <= 1'b0;
        wa       <= 8'h00;
        ra       <= 8'h00;
      end else begin
        tx_valid <= rd_pend;
        tx_data  <= rd_pend ? mem[ra] : 8'h00;
        rd_pend  <= cmd_valid && (cmd_data[9:8] == 2'b11) && !mute[g];
        if (cmd_valid) begin
          case (cmd_data[9:8])
            2'b00:   wa <= cmd_data[7:0];
            2'b01:   mem[wa] <= cmd_data[7:0];
            2'b10:   ra <= cmd_data[7:0];
            default: ;
          endcase
        end
      end
    end

    always @(negedge clk) begin
      n = n + 1;
      if (rst[g]) begin
        first_pending = 0;
      end else begin
        if (cmd_valid) begin
          checks++;
          if (cmd_size(g) == 0) begin
            errors++;
            $display("FAIL cmd_unexpected dut%0d got %h required none", g, cmd_data);
          end else begin
            want_cmd = pop_cmd(g);
            if (cmd_data !== want_cmd) begin
              errors++;
              $display("FAIL cmd_word dut%0d got %h required %h", g, cmd_data, want_cmd);
            end
          end
          want_n = first_pending ? acc_n + 1 : last_n + GAPV + 1;
          first_pending = 0;
          checks++;
          if (n != want_n) begin
            errors++;
            $display("FAIL cmd_time dut%0d got cycle %0d required %0d", g, n, want_n);
          end
          last_n = n;
          if (cmd_data[8]) data_n = n;
        end
        if (rsp_valid) begin
          checks++;
          if (rsp_size(g) == 0) begin
            errors++;
            $display("FAIL rsp_unexpected dut%0d got %b/%h required none", g, rsp_err, rsp_data);
          end else begin
            want_rsp = pop_rsp(g);
            if ({rsp_err, rsp_data} !== want_rsp) begin
              errors++;
              $display("FAIL rsp dut%0d got err=%b data=%h required err=%b data=%h",
                       g, rsp_err, rsp_data, want_rsp[8], want_rsp[7:0]);
            end
          end
          want_n = data_n + (rsp_err ? TOV + 1 : 2);
          checks++;
          if (n != want_n) begin
            errors++;
            $display("FAIL rsp_time dut%0d got cycle %0d required %0d", g, n, want_n);
          end
        end
        if (req_valid[g] && req_ready) begin
          acc_n = n;
          first_pending = 1;
        end
      end
    end
  end

  function automatic logic get_ready(input int d);
    return (d == 0) ? g_ch[0].req_ready : g_ch[1].req_ready;
  endfunction

  function automatic logic [22:0] get_outs(input int d);
    if (d == 0)
      return {g_ch[0].req_ready, g_ch[0].cmd_valid, g_ch[0].cmd_data, g_ch[0].rsp_valid,
              g_ch[0].rsp_data, g_ch[0].rsp_err, g_ch[0].busy};
    return {g_ch[1].req_ready, g_ch[1].cmd_valid, g_ch[1].cmd_data, g_ch[1].rsp_valid,
            g_ch[1].rsp_data, g_ch[1].rsp_err, g_ch[1].busy};
  endfunction

  task automatic check_idle(input int d, input string name);
    logic [22:0] got;
    got = get_outs(d);
    checks++;
    if (got !== {1'b1, 22'h0}) begin
      errors++;
      $display("FAIL %s dut%0d got %h required %h", name, d, got, {1'b1, 22'h0});
    end
  endtask

  task automatic init_ref(input int d);
    for (int i = 0; i < 256; i++) ref_mem[d][i] = 8'(i) ^ 8'h5A;
    wc_v[d] = 0;
    rc_v[d] = 0;
  endtask

  // Request-level model: expected words and responses follow from the cache rule and memory contents.
  task automatic do_req(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        input bit m);
    bit hit;
    int budget;
    hit = (d == 0) && (wr ? (wc_v[d] && wc[d] == a) : (rc_v[d] && rc[d] == a));
    if (wr) begin
      if (!hit) begin
        push_cmd(d, {2'b00, a});
        wc_v[d] = 1;
        wc[d]   = a;
      end
      push_cmd(d, {2'b01, wd});
      ref_mem[d][a] = wd;
    end else begin
      if (!hit) begin
        push_cmd(d, {2'b10, a});
        rc_v[d] = 1;
        rc[d]   = a;
      end
      push_cmd(d, {2'b11, 8'h00});
      if (m) begin
        push_rsp(d, {1'b1, 8'h00});
        rc_v[d] = 0;
      end else begin
        push_rsp(d, {1'b0, ref_mem[d][a]});
      end
    end
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    budget = 0;
    while (!get_ready(d) && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    checks++;
    if (!get_ready(d)) begin
      errors++;
      $display("FAIL req_ready_timeout dut%0d got 0 required 1", d);
    end
    @(posedge clk);
    mute[d] = m;
    #1;
    req_valid[d] = 1'b0;
  endtask

  initial begin
    int d;
    bit wr, m;
    logic [7:0] a;
    int budget;
    rst = 2'b11;
    req_valid = 2'b00;
    req_write = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = 8'h00;
      req_wdata[i] = 8'h00;
      mute[i]      = 0;
      init_ref(i);
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "reset_state");
    check_idle(1, "reset_state");
    rst = 2'b00;
    @(posedge clk);
    #1;

    do_req(0, 1, 8'h12, 8'h3C, 0);
    do_req(0, 0, 8'h12, 8'h00, 0);
    do_req(0, 1, 8'h12, 8'h55, 0);
    do_req(0, 0, 8'h12, 8'h00, 1);
    do_req(0, 0, 8'h12, 8'h00, 0);

    do_req(1, 1, 8'h12, 8'h3C, 0);
    do_req(1, 1, 8'h12, 8'h3D, 0);
    do_req(1, 0, 8'h12, 8'h00, 0);
    do_req(1, 0, 8'h40, 8'h00, 1);

    // Abort a read in its gap: neither the 11 word nor a response may appear.
    do_req(1, 0, 8'h20, 8'h00, 0);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    void'(exp_cmd1.pop_back());
    void'(exp_rsp1.pop_back());
    init_ref(1);
    @(posedge clk);
    #1;
    check_idle(1, "mid_reset");
    rst[1] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    do_req(1, 0, 8'h20, 8'h00, 0);

    for (int i = 0; i < 150; i++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 8'h30 + 8'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = 8'($urandom);
      m  = !wr && ($urandom_range(0, 7) == 0);
      do_req(d, wr, a, 8'($urandom), m);
    end

    budget = 0;
    while ((cmd_size(0) + cmd_size(1) + rsp_size(0) + rsp_size(1)) != 0 && budget < 300) begin
      @(posedge clk);
      budget++;
    end
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cmd_size(i) != 0 || rsp_size(i) != 0) begin
        errors++;
        $display("FAIL drain dut%0d got %0d/%0d pending required 0/0", i, cmd_size(i), rsp_size(i));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
